// File: rtl/lifo_mc.sv
// lifo_mc: several independent LIFO stacks sharing one async-read RAM
module lifo_mc #(
  parameter int CHANNELS  = 4,
  parameter int DEPTH     = 16,
  parameter int WIDTH     = 16,
  parameter bit OVERWRITE = 1,
  localparam int CW = CHANNELS > 1 ? $clog2(CHANNELS) : 1,
  localparam int PW = $clog2(DEPTH),
  localparam int DW = PW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clken,
  input  logic             clr,
  input  logic [CW-1:0]    ch,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out,
  output logic [DW-1:0]    depth,
  output logic             full,
  output logic             empty,
  output logic             ovf,
  output logic             unf
);
  localparam int NCH = 2 ** CW;
  logic [WIDTH-1:0] mem [2 ** (CW + PW)];
  logic [PW-1:0] tp [NCH];
  logic [DW-1:0] d [NCH];
  logic [PW-1:0] tp_s, tp_n, wr_ptr;
  logic [DW-1:0] d_s, d_n;
  logic rep, psh, pp, adv, wr_en, ovf_set, unf_set;
  // Decode the operation on the selected channel and its next state
  always_comb begin
    tp_s    = tp[ch];
    d_s     = d[ch];
    full    = d_s == DW'(DEPTH);
    empty   = d_s == '0;
    depth   = d_s;
    out     = empty ? '0 : mem[{ch, tp_s}];
    rep     = push & pop & ~empty;
    psh     = push & (~pop | empty);
    pp      = pop & ~push;
    adv     = psh & (~full | OVERWRITE);
    wr_en   = clken & ~clr & (rep | adv);
    wr_ptr  = rep ? tp_s : tp_s + 1'b1;
    tp_n    = adv ? tp_s + 1'b1 : (pp & ~empty) ? tp_s - 1'b1 : tp_s;
    d_n     = (psh & ~full) ? d_s + 1'b1 : (pp & ~empty) ? d_s - 1'b1 : d_s;
    ovf_set = psh & full;
    unf_set = pop & empty;
  end
  // Per-channel pointers, counts and sticky flags
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NCH; i++) begin
        tp[i] <= '1;
        d[i]  <= '0;
      end
      ovf <= 1'b0;
      unf <= 1'b0;
    end else if (clken) begin
      if (clr) begin
        for (int i = 0; i < NCH; i++) begin
          tp[i] <= '1;
          d[i]  <= '0;
        end
        ovf <= 1'b0;
        unf <= 1'b0;
      end else begin
        tp[ch] <= tp_n;
        d[ch]  <= d_n;
        ovf    <= ovf | ovf_set;
        unf    <= unf | unf_set;
      end
    end
  end
  // Shared stack storage; contents survive reset and clear
  always_ff @(posedge clk) begin
    if (wr_en) mem[{ch, wr_ptr}] <= in;
  end
endmodule

// File: doc/lifo_mc.md
# lifo_mc

Multi-channel, parameterised LIFO for the KS-10 FPGA. It holds CHANNELS independent stacks of DEPTH words of WIDTH bits in one shared dual-port RAM. Full-stack behaviour is selectable: overwrite the oldest entry, or reject the push and flag it. Used where several contexts need private call/return or save stacks without one RAM per context.

## Interface
- CHANNELS, 4: number of independent stacks; >=1.
- DEPTH, 16: entries per stack; power of two, >=2.
- WIDTH, 16: data word width.
- OVERWRITE, 1: 1 = push to a full stack discards the oldest entry; 0 = push to a full stack is rejected.
- clk  input  1  Clock; all state changes on rising edge.
- rst  input  1  Reset; asynchronous, active-low; clears all pointers, depths and flags.
- clken  input  1  Clock enable; when low, no state changes (including clr).
- clr  input  1  Synchronous clear of all channels and both error flags (qualified by clken).
- ch  input  max(1,clog2(CHANNELS))  Channel selected for push/pop/out/status.
- push  input  1  Push `in` onto the selected stack.
- pop  input  1  Pop the selected stack.
- in  input  WIDTH  Push data.
- out  output  WIDTH  Top of the selected stack; 0 when that stack is empty.
- depth  output  clog2(DEPTH)+1  Entry count of the selected stack, 0..DEPTH.
- full  output  1  Selected stack depth == DEPTH.
- empty  output  1  Selected stack depth == 0.
- ovf  output  1  Sticky: a push was rejected or overwrote an entry, on any channel.
- unf  output  1  Sticky: a pop was attempted on an empty stack, on any channel.

## Operation
- Per-channel state: top pointer tp[c] (clog2(DEPTH) bits, modulo DEPTH) and count d[c] (clog2(DEPTH)+1 bits). RAM address = {c, pointer}.
- Reset and clr values: tp = DEPTH-1, d = 0, ovf = 0, unf = 0. RAM contents are not cleared. Outputs after reset: out = 0, depth = 0, empty = 1, full = 0, ovf = 0, unf = 0.
- Only the selected channel changes per cycle. Every other channel holds its state.
- Push only, d<DEPTH: write RAM[c, tp+1] = in; tp += 1; d += 1.
- Push only, d==DEPTH, OVERWRITE=1: write RAM[c, tp+1] = in; tp += 1 (wraps); d unchanged; ovf set. The slot written is the oldest entry.
- Push only, d==DEPTH, OVERWRITE=0: no write; tp and d unchanged; ovf set.
- Pop only, d>0: tp -= 1; d -= 1.
- Pop only, d==0: no change except unf set.
- Push and pop together, d>0: replace the top. Write RAM[c, tp] = in; tp and d unchanged. Not an overflow.
- Push and pop together, d==0: treated as a push; unf set.
- Pointer arithmetic wraps modulo DEPTH. Count saturates at 0 and DEPTH by the rules above and never wraps.
- clr has priority over push and pop in the same cycle.
- out = RAM[ch, tp[ch]] when d[ch]>0, else 0. It is a combinational read from registered state; the RAM is distributed/async-read.

## Timing
- A push or pop at rising edge k (clken=1) is visible on out, depth, full and empty immediately after edge k, with zero added latency.
- Changing ch updates out and the status outputs combinationally in the same cycle.
- ovf and unf assert after the offending edge and stay high until rst or clr.
- Asserting rst at any time, including mid-burst, forces all reset values at once and asynchronously. Deassertion is synchronised outside this block.
- clken=0: push, pop and clr are ignored. Outputs still track ch.

## Test plan
- Reset, then on ch=0 push 0x1111, 0x2222, 0x3333 -> out=0x3333, depth=3. Pop three times -> out 0x2222, then 0x1111, then 0 with empty=1, unf=0. A fourth pop -> unf=1, depth=0.
- Channel isolation: push 0xA0 on ch=1 and 0xB0 on ch=2 -> ch=1 shows 0xA0/depth 1, ch=2 shows 0xB0/depth 1, ch=0 shows empty. Pop ch=2 -> ch=1 still shows 0xA0.
- OVERWRITE=1, DEPTH=4: push 1..6 on ch=0 -> full=1, depth=4, ovf=1. Four pops return 6, 5, 4, 3, then empty=1.
- OVERWRITE=0, DEPTH=4: push 1..6 -> depth=4, ovf=1. Pops return 4, 3, 2, 1.
- Simultaneous push+pop with top=0x55 and depth 2 -> out=in (e.g. 0x77), depth stays 2, ovf=0. The same on an empty channel -> depth=1, unf=1.
- Controls: clken=0 with push -> no change. clr with push -> all channels empty and flags 0. rst asserted mid-sequence -> outputs at reset values before the next clk edge.
